// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// MUL/DIV sequencer states, forward-select codes, register r0 helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Later-stage writer of src, ignoring r0.
  function automatic logic reg_hit(
    input logic       wr,
    input logic [4:0] dst,
    input logic [4:0] src
  );
    return wr && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/md_seq.sv
// MUL/DIV busy sequencer: IDLE/BUSY/DONE FSM plus down-counter.
// Ports: clock, resetn, start_ok in; md_busy, md_done registered out.
module md_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clock,
  input  logic resetn,
  input  logic start_ok,
  output logic md_busy,
  output logic md_done
);

  localparam logic [7:0] RELOAD = 8'(MD_CYCLES - 2);

  md_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = BUSY;
          cnt_d   = RELOAD;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        // Back-to-back launch: DONE is the last busy cycle.
        if (start_ok) begin
          state_d = BUSY;
          cnt_d   = RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard/stall/flush control, forwarding select, stall counter.
// Ports: see header list; optional forwarding via macro PIPE_FWD_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [4:0]       ern,
  input  logic [4:0]       mrn,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic             br_taken,
  input  logic             md_start,
  input  logic             md_use,
  output logic             wpcir,
  output logic             if_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [CNT_W-1:0] stall_cnt
);

  logic haz_e;
  logic data_haz;
  logic md_haz;
  logic stall;
  logic start_ok;
  logic [1:0] fwda_d, fwdb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign haz_e = (use_rs && reg_hit(ewreg, ern, rs))
              || (use_rt && reg_hit(ewreg, ern, rt));

`ifdef PIPE_FWD_EN
  assign data_haz = haz_e && em2reg;

  // EX load data is not ready yet, so it falls through to MEM.
  always_comb begin
    fwda_d = FWD_RF;
    fwdb_d = FWD_RF;
    if (resetn) begin
      priority case (1'b1)
        reg_hit(ewreg, ern, rs) && !em2reg: fwda_d = FWD_EXALU;
        reg_hit(mwreg, mrn, rs):
          fwda_d = mm2reg ? FWD_MEMLD : FWD_MEMALU;
        default: fwda_d = FWD_RF;
      endcase
      priority case (1'b1)
        reg_hit(ewreg, ern, rt) && !em2reg: fwdb_d = FWD_EXALU;
        reg_hit(mwreg, mrn, rt):
          fwdb_d = mm2reg ? FWD_MEMLD : FWD_MEMALU;
        default: fwdb_d = FWD_RF;
      endcase
    end
  end
`else
  logic haz_m;
  logic unused_ld;

  assign haz_m = (use_rs && reg_hit(mwreg, mrn, rs))
              || (use_rt && reg_hit(mwreg, mrn, rt));
  assign data_haz  = haz_e || haz_m;
  assign fwda_d    = FWD_RF;
  assign fwdb_d    = FWD_RF;
  assign unused_ld = ^{em2reg, mm2reg};
`endif

  assign md_haz = (md_start || md_use) && md_busy && !md_done;

  // Outputs read idle while reset is held, whatever ID presents.
  assign stall    = resetn && (data_haz || md_haz);
  assign wpcir    = !stall;
  assign if_flush = resetn && br_taken && !stall;
  assign start_ok = md_start && !stall && !br_taken;
  assign fwda     = fwda_d;
  assign fwdb     = fwdb_d;

  md_seq #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md_seq (
    .clock   (clock),
    .resetn  (resetn),
    .start_ok(start_ok),
    .md_busy (md_busy),
    .md_done (md_done)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed checks of pipe_hazard_ctrl against a
// cycle-level reference model (MD_CYCLES=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int MDC  = 4;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic [4:0]    rs, rt, ern, mrn;
  logic          use_rs, use_rt;
  logic          ewreg, em2reg, mwreg, mm2reg;
  logic          br_taken, md_start, md_use;
  logic          wpcir, if_flush, md_busy, md_done;
  logic [1:0]    fwda, fwdb;
  logic [CW-1:0] stall_cnt;

  pipe_hazard_ctrl #(
    .MD_CYCLES(MDC),
    .CNT_W    (CW)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .rs       (rs),
    .rt       (rt),
    .use_rs   (use_rs),
    .use_rt   (use_rt),
    .ern      (ern),
    .mrn      (mrn),
    .ewreg    (ewreg),
    .em2reg   (em2reg),
    .mwreg    (mwreg),
    .mm2reg   (mm2reg),
    .br_taken (br_taken),
    .md_start (md_start),
    .md_use   (md_use),
    .wpcir    (wpcir),
    .if_flush (if_flush),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .fwda     (fwda),
    .fwdb     (fwdb),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state: busy cycles left, stall count.
  int rem  = 0;
  int scnt = 0;

  int e_st, e_fl, e_busy, e_done, e_fa, e_fb;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int hit(int wr, int dst, int src);
    return (wr != 0 && dst != 0 && dst == src) ? 1 : 0;
  endfunction

  function automatic int fsel(int src);
    if (hit(ewreg, ern, src) != 0 && em2reg == 0) return 1;
    if (hit(mwreg, mrn, src) != 0) return (mm2reg != 0) ? 3 : 2;
    return 0;
  endfunction

  task automatic model_eval();
    int he, hm, dh, mh;
    he = (use_rs && hit(ewreg, ern, rs) != 0)
      || (use_rt && hit(ewreg, ern, rt) != 0) ? 1 : 0;
    hm = (use_rs && hit(mwreg, mrn, rs) != 0)
      || (use_rt && hit(mwreg, mrn, rt) != 0) ? 1 : 0;
`ifdef PIPE_FWD_EN
    dh = (he != 0 && em2reg) ? 1 : 0;
    e_fa = fsel(rs);
    e_fb = fsel(rt);
`else
    dh = (he != 0 || hm != 0) ? 1 : 0;
    e_fa = 0;
    e_fb = 0;
`endif
    e_busy = (rem > 0) ? 1 : 0;
    e_done = (rem == 1) ? 1 : 0;
    mh = ((md_start || md_use) && e_busy != 0 && e_done == 0) ? 1 : 0;
    e_st = (dh != 0 || mh != 0) ? 1 : 0;
    if (!resetn) begin
      e_st = 0;
      e_fa = 0;
      e_fb = 0;
    end
    e_fl = (resetn && br_taken && e_st == 0) ? 1 : 0;
  endtask

  task automatic cycle();
    #1;
    model_eval();
    chk("wpcir", 32'(wpcir), 32'(e_st == 0));
    chk("if_flush", 32'(if_flush), 32'(e_fl));
    chk("md_busy", 32'(md_busy), 32'(e_busy));
    chk("md_done", 32'(md_done), 32'(e_done));
    chk("fwda", 32'(fwda), 32'(e_fa));
    chk("fwdb", 32'(fwdb), 32'(e_fb));
    chk("stall_cnt", 32'(stall_cnt), 32'(scnt));
    if (!resetn) begin
      rem  = 0;
      scnt = 0;
    end else begin
      if (e_st != 0 && scnt < SMAX) scnt++;
      if (md_start && e_st == 0 && !br_taken) rem = MDC;
      else if (rem > 0) rem--;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clr();
    rs = 0; rt = 0; ern = 0; mrn = 0;
    use_rs = 0; use_rt = 0;
    ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
    br_taken = 0; md_start = 0; md_use = 0;
  endtask

  task automatic rand_in();
    rs       = 5'($urandom_range(0, 3));
    rt       = 5'($urandom_range(0, 3));
    ern      = 5'($urandom_range(0, 3));
    mrn      = 5'($urandom_range(0, 3));
    use_rs   = 1'($urandom_range(0, 1));
    use_rt   = 1'($urandom_range(0, 1));
    ewreg    = 1'($urandom_range(0, 1));
    em2reg   = 1'($urandom_range(0, 1));
    mwreg    = 1'($urandom_range(0, 1));
    mm2reg   = 1'($urandom_range(0, 1));
    br_taken = ($urandom_range(0, 3) == 0);
    md_start = ($urandom_range(0, 5) == 0);
    md_use   = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    clr();
    #1 resetn = 1'b0;
    rem  = 0;
    scnt = 0;
    @(negedge clock);

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      rand_in();
      #1;
      chk("rst_wpcir", 32'(wpcir), 32'd1);
      chk("rst_flush", 32'(if_flush), 32'd0);
      chk("rst_busy", 32'(md_busy), 32'd0);
      chk("rst_cnt", 32'(stall_cnt), 32'd0);
      cycle();
    end
    resetn = 1'b1;

    for (int i = 0; i < 400; i++) begin
      rand_in();
      cycle();
    end

    clr();
    for (int i = 0; i < 6; i++) cycle();

    // Load-use on rs=5.
    ewreg = 1; em2reg = 1; ern = 5; rs = 5; use_rs = 1;
    #1 chk("lu_stall", 32'(wpcir), 32'd0);
    cycle();
    clr();
    mwreg = 1; mm2reg = 1; mrn = 5; rs = 5; use_rs = 1;
    #1;
`ifdef PIPE_FWD_EN
    chk("lu_go", 32'(wpcir), 32'd1);
    chk("lu_fwda", 32'(fwda), 32'd3);
`else
    chk("lu_stall2", 32'(wpcir), 32'd0);
`endif
    cycle();
    clr();
    rs = 5; use_rs = 1;
    #1 chk("lu_free", 32'(wpcir), 32'd1);
    cycle();

    // EX ALU result on rs/rt, then same with ern=0.
    clr();
    ewreg = 1; ern = 3; rs = 3; rt = 3; use_rs = 1; use_rt = 1;
    #1;
`ifdef PIPE_FWD_EN
    chk("alu_wpcir", 32'(wpcir), 32'd1);
    chk("alu_fwda", 32'(fwda), 32'd1);
    chk("alu_fwdb", 32'(fwdb), 32'd1);
`else
    chk("alu_stall", 32'(wpcir), 32'd0);
    chk("alu_fwda", 32'(fwda), 32'd0);
`endif
    cycle();
    ern = 0; rs = 0; rt = 0;
    #1 chk("r0_fwda", 32'(fwda), 32'd0);
    chk("r0_wpcir", 32'(wpcir), 32'd1);
    cycle();

    // Branch during load-use stall, then free.
    clr();
    ewreg = 1; em2reg = 1; ern = 5; rs = 5; use_rs = 1; br_taken = 1;
    #1 chk("br_stall", 32'(if_flush), 32'd0);
    cycle();
    clr();
    br_taken = 1;
    #1 chk("br_flush", 32'(if_flush), 32'd1);
    chk("br_wpcir", 32'(wpcir), 32'd1);
    cycle();

    // MUL/DIV launch, dependent op, relaunch in DONE.
    clr();
    md_start = 1;
    cycle();
    md_start = 0; md_use = 1;
    for (int k = 1; k <= 3; k++) begin
      #1 chk("md_busy_k", 32'(md_busy), 32'd1);
      chk("md_done_k", 32'(md_done), 32'd0);
      chk("md_wait", 32'(wpcir), 32'd0);
      cycle();
    end
    md_start = 1;
    #1 chk("md_done4", 32'(md_done), 32'd1);
    chk("md_issue", 32'(wpcir), 32'd1);
    cycle();
    md_start = 0; md_use = 0;
    #1 chk("md_relaunch", 32'(md_busy), 32'd1);
    chk("md_nodone", 32'(md_done), 32'd0);
    for (int i = 0; i < 5; i++) cycle();

    // Async reset with md_cnt=2, md_use afterwards issues.
    clr();
    md_start = 1;
    cycle();
    md_start = 0; md_use = 1;
    #1 chk("ar_busy", 32'(md_busy), 32'd1);
    resetn = 1'b0;
    rem  = 0;
    scnt = 0;
    #1 chk("ar_idle", 32'(md_busy), 32'd0);
    chk("ar_cnt", 32'(stall_cnt), 32'd0);
    resetn = 1'b1;
    #1 chk("ar_issue", 32'(wpcir), 32'd1);
    cycle();

    // Stall counter saturation.
    clr();
    ewreg = 1; em2reg = 1; ern = 7; rt = 7; use_rt = 1;
    for (int i = 0; i < SMAX + 4; i++) cycle();
    #1 chk("sat", 32'(stall_cnt), 32'(SMAX));
    clr();

    for (int i = 0; i < 300; i++) begin
      rand_in();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
